// File: rtl/readout_pkg.sv
// readout_pkg: shared types and constants for the counter readout sequencer.
// Holds the FSM state encoding, the frame cause codes and the default frame geometry.
// Latency: none (types and constants only). Backpressure: none.
package readout_pkg;

  // Default frame geometry: channel words 0..7, then the RTC word.
  localparam int N_WORDS_DEF = 9;
  localparam int WORD_W_DEF  = 12;
  localparam int RTC_SEL     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    CLEAR = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_HOST = 2'd1,
    CAUSE_CH   = 2'd2,
    CAUSE_RTC  = 2'd3
  } cause_e;

endpackage

// File: rtl/readout_sequencer_arbiter.sv
// req_arbiter: rising-edge detects the three readout requests, holds one pending bit
// per source and offers the highest-priority pending source (RTC > ch > host).
// Latency: an edge sampled at cycle t shows up on grant_valid_o at t+1. Backpressure:
// none; pending bits persist until acked, and repeat edges from a pending source merge.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   ovf_rtc_i          RTC overflow level
//   ovf_ch_i           OR of channel overflow levels
//   host_req_i         host request level
//   grant_ack_i        sequencer accepts the offered grant (clears that pending bit)
//   grant_valid_o      at least one source pending
//   grant_cause_o      cause code of the highest-priority pending source
module req_arbiter
  import readout_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ovf_rtc_i,
  input  logic       ovf_ch_i,
  input  logic       host_req_i,
  input  logic       grant_ack_i,
  output logic       grant_valid_o,
  output logic [1:0] grant_cause_o
);

  // Bit order everywhere: [2] RTC, [1] ch, [0] host.
  logic [2:0] req_w;
  logic [2:0] prev_q;
  logic [2:0] pend_q, pend_d;
  logic [2:0] edge_w;
  logic [2:0] grant_oh;
  logic [2:0] clr_w;

  assign req_w  = {ovf_rtc_i, ovf_ch_i, host_req_i};
  assign edge_w = req_w & ~prev_q;

  always_comb begin
    grant_oh      = 3'b000;
    grant_cause_o = CAUSE_NONE;
    if (pend_q[2]) begin
      grant_oh      = 3'b100;
      grant_cause_o = CAUSE_RTC;
    end else if (pend_q[1]) begin
      grant_oh      = 3'b010;
      grant_cause_o = CAUSE_CH;
    end else if (pend_q[0]) begin
      grant_oh      = 3'b001;
      grant_cause_o = CAUSE_HOST;
    end
  end

  assign grant_valid_o = |pend_q;
  assign clr_w         = grant_ack_i ? grant_oh : 3'b000;

  // A fresh edge on the source being granted this cycle is a new request, so set wins.
  assign pend_d = (pend_q & ~clr_w) | edge_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 3'b000;
      pend_q <= 3'b000;
    end else begin
      prev_q <= req_w;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/readout_sequencer.sv
// readout_sequencer: frame controller that walks the word mux, drives one PISO load and
// WORD_W shift cycles per word, then clears the counters.
// Latency: request edge at t -> first LOAD at t+2; frame = N_WORDS*(1+WORD_W)+1 cycles.
// Backpressure: none; requests arriving mid-frame stay pending and run after CLEAR.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   ovf_rtc        RTC overflow level
//   ovf_ch         OR of channel overflows
//   host_req       host readout request level
//   sel            word mux select (0..N_WORDS-1)
//   sl             PISO control, 1 = parallel load, 0 = shift
//   frame_valid    serial output carries a payload bit this cycle
//   frame_start    pulse on the first LOAD of a frame
//   out_rst        one-cycle counter clear at frame end
//   done           pulse coincident with out_rst
//   busy           high from first LOAD through CLEAR
//   cause          latched cause of the current/last frame
module readout_sequencer
  import readout_pkg::*;
#(
  parameter int N_WORDS = N_WORDS_DEF,
  parameter int WORD_W  = WORD_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ovf_rtc,
  input  logic       ovf_ch,
  input  logic       host_req,
  output logic [3:0] sel,
  output logic       sl,
  output logic       frame_valid,
  output logic       frame_start,
  output logic       out_rst,
  output logic       done,
  output logic       busy,
  output logic [1:0] cause
);

  localparam logic [3:0] LAST_SEL = 4'(N_WORDS - 1);
  localparam logic [3:0] LAST_BIT = 4'(WORD_W - 1);

  state_e     state_q, state_d;
  logic [3:0] sel_q, sel_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] cause_q, cause_d;
  logic       sl_q, sl_d;
  logic       fv_q, fv_d;
  logic       fs_q, fs_d;
  logic       clr_q, clr_d;
  logic       busy_q, busy_d;

  logic       grant_valid;
  logic [1:0] grant_cause;
  logic       grant_ack;

  req_arbiter u_arb (
    .clk          (clk),
    .reset        (reset),
    .ovf_rtc_i    (ovf_rtc),
    .ovf_ch_i     (ovf_ch),
    .host_req_i   (host_req),
    .grant_ack_i  (grant_ack),
    .grant_valid_o(grant_valid),
    .grant_cause_o(grant_cause)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    bit_cnt_d = bit_cnt_q;
    cause_d   = cause_q;
    grant_ack = 1'b0;

    case (state_q)
      IDLE: begin
        sel_d = 4'd0;
        if (grant_valid) begin
          grant_ack = 1'b1;
          cause_d   = grant_cause;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        bit_cnt_d = 4'd0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == LAST_BIT) begin
          if (sel_q < LAST_SEL) begin
            sel_d   = sel_q + 4'd1;
            state_d = LOAD;
          end else begin
            state_d = CLEAR;
          end
        end
      end
      CLEAR: begin
        sel_d   = 4'd0;
        state_d = IDLE;
      end
      default: begin
        sel_d   = 4'd0;
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so every output is a flop.
    sl_d   = (state_d == LOAD);
    fv_d   = (state_d == SHIFT);
    fs_d   = (state_q == IDLE) && (state_d == LOAD);
    clr_d  = (state_d == CLEAR);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= 4'd0;
      bit_cnt_q <= 4'd0;
      cause_q   <= CAUSE_NONE;
      sl_q      <= 1'b0;
      fv_q      <= 1'b0;
      fs_q      <= 1'b0;
      clr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      bit_cnt_q <= bit_cnt_d;
      cause_q   <= cause_d;
      sl_q      <= sl_d;
      fv_q      <= fv_d;
      fs_q      <= fs_d;
      clr_q     <= clr_d;
      busy_q    <= busy_d;
    end
  end

  assign sel         = sel_q;
  assign sl          = sl_q;
  assign frame_valid = fv_q;
  assign frame_start = fs_q;
  assign out_rst     = clr_q;
  assign done        = clr_q;
  assign busy        = busy_q;
  assign cause       = cause_q;

endmodule

// File: tb/tb_readout_sequencer.sv
module tb_readout_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       ovf_rtc, ovf_ch, host_req;
  logic [3:0] sel;
  logic       sl, frame_valid, frame_start, out_rst, done, busy;
  logic [1:0] cause;

  always #5 clk = ~clk;

  readout_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .ovf_rtc    (ovf_rtc),
    .ovf_ch     (ovf_ch),
    .host_req   (host_req),
    .sel        (sel),
    .sl         (sl),
    .frame_valid(frame_valid),
    .frame_start(frame_start),
    .out_rst    (out_rst),
    .done       (done),
    .busy       (busy),
    .cause      (cause)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log, sampled on the falling edge.
  int fs_cyc[$];
  int fs_cause[$];
  int load_sel[$];
  int or_cyc[$];
  int fv_cnt   = 0;
  int bad_done = 0;
  int bad_sel  = 0;

  always @(negedge clk) begin
    if (frame_start === 1'b1) begin
      fs_cyc.push_back(cyc);
      fs_cause.push_back(int'(cause));
    end
    if (sl === 1'b1) load_sel.push_back(int'(sel));
    if (out_rst === 1'b1) or_cyc.push_back(cyc);
    if (frame_valid === 1'b1) fv_cnt++;
    if (cyc > 1 && done !== out_rst) bad_done++;
    if (cyc > 1 && sel > 4'd8) bad_sel++;
  end

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Returns at cycle n, 1 time unit after the rising edge.
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Positions at the falling edge of cycle n.
  task automatic samp(input int n);
    wait_cyc(n);
    @(negedge clk);
  endtask

  int s_fs, s_ls, s_or, fv0;

  initial begin
    reset    = 1'b1;
    ovf_rtc  = 1'b0;
    ovf_ch   = 1'b0;
    host_req = 1'b0;

    samp(1);
    check("reset_outputs", int'({sel, sl, frame_valid, frame_start, out_rst, done, busy, cause}), 0);
    wait_cyc(2);
    reset = 1'b0;

    // Single host frame: edge at 10, first LOAD at 12, CLEAR at 129.
    s_fs = fs_cyc.size(); s_ls = load_sel.size(); s_or = or_cyc.size(); fv0 = fv_cnt;
    wait_cyc(10);
    host_req = 1'b1;
    samp(11);
    check("t1_not_busy_yet", int'(busy), 0);
    samp(12);
    check("t1_load_cycle", int'({sl, frame_start, busy, sel}), int'({1'b1, 1'b1, 1'b1, 4'd0}));
    check("t1_cause", int'(cause), 1);
    samp(13);
    check("t1_first_shift", int'({sl, frame_valid, frame_start}), int'({1'b0, 1'b1, 1'b0}));
    wait_cyc(15);
    host_req = 1'b0;
    samp(135);
    check("t1_frames", fs_cyc.size() - s_fs, 1);
    check("t1_start_cyc", at(fs_cyc, s_fs), 12);
    check("t1_fv_cycles", fv_cnt - fv0, 108);
    check("t1_loads", load_sel.size() - s_ls, 9);
    for (int i = 0; i < 9; i++) check("t1_sel_step", at(load_sel, s_ls + i), i);
    check("t1_clears", or_cyc.size() - s_or, 1);
    check("t1_clear_cyc", at(or_cyc, s_or), 129);
    check("t1_idle_after", int'({busy, sel}), 0);

    // ch ovf and host together: ch first, host back-to-back.
    s_fs = fs_cyc.size(); s_or = or_cyc.size();
    wait_cyc(200);
    ovf_ch = 1'b1; host_req = 1'b1;
    wait_cyc(205);
    ovf_ch = 1'b0; host_req = 1'b0;
    samp(443);
    check("t2_frames", fs_cyc.size() - s_fs, 2);
    check("t2_f1_start", at(fs_cyc, s_fs), 202);
    check("t2_f1_cause", at(fs_cause, s_fs), 2);
    check("t2_f1_clear", at(or_cyc, s_or), 319);
    check("t2_f2_start", at(fs_cyc, s_fs + 1), 321);
    check("t2_f2_cause", at(fs_cause, s_fs + 1), 1);
    check("t2_f2_clear", at(or_cyc, s_or + 1), 438);

    // RTC overflow during word 4 of a ch frame.
    s_fs = fs_cyc.size(); s_ls = load_sel.size(); s_or = or_cyc.size(); fv0 = fv_cnt;
    wait_cyc(500);
    ovf_ch = 1'b1;
    wait_cyc(505);
    ovf_ch = 1'b0;
    wait_cyc(558);
    ovf_rtc = 1'b1;
    samp(560);
    check("t3_mid_cause", int'(cause), 2);
    check("t3_mid_sel", int'(sel), 4);
    wait_cyc(563);
    ovf_rtc = 1'b0;
    samp(745);
    check("t3_frames", fs_cyc.size() - s_fs, 2);
    check("t3_f1_clear", at(or_cyc, s_or), 619);
    check("t3_f1_last_sel", at(load_sel, s_ls + 8), 8);
    check("t3_f2_start", at(fs_cyc, s_fs + 1), 621);
    check("t3_f2_cause", at(fs_cause, s_fs + 1), 3);
    check("t3_fv_cycles", fv_cnt - fv0, 216);

    // Level held 300 cycles yields one frame.
    s_fs = fs_cyc.size(); s_or = or_cyc.size();
    wait_cyc(800);
    host_req = 1'b1;
    wait_cyc(1100);
    host_req = 1'b0;
    samp(1110);
    check("t4_frames", fs_cyc.size() - s_fs, 1);
    check("t4_clear_cyc", at(or_cyc, s_or), 919);

    // Reset during word 5 shift; fresh frame afterwards.
    s_fs = fs_cyc.size(); s_ls = load_sel.size(); s_or = or_cyc.size();
    wait_cyc(1200);
    host_req = 1'b1;
    wait_cyc(1205);
    host_req = 1'b0;
    samp(1272);
    check("t5_in_word5", int'({frame_valid, sel}), int'({1'b1, 4'd5}));
    wait_cyc(1273);
    reset = 1'b1;
    wait_cyc(1274);
    reset = 1'b0;
    samp(1274);
    check("t5_outputs_reset", int'({sel, sl, frame_valid, frame_start, out_rst, done, busy, cause}), 0);
    samp(1300);
    check("t5_no_clear", or_cyc.size() - s_or, 0);
    check("t5_not_resumed", int'(busy), 0);
    s_ls = load_sel.size();
    wait_cyc(1310);
    host_req = 1'b1;
    wait_cyc(1315);
    host_req = 1'b0;
    samp(1440);
    check("t5_restart_start", at(fs_cyc, s_fs + 1), 1312);
    check("t5_restart_sel0", at(load_sel, s_ls), 0);
    check("t5_restart_clear", at(or_cyc, s_or), 1429);

    // Two host edges during one frame: one follow-up frame only.
    s_fs = fs_cyc.size(); s_or = or_cyc.size();
    wait_cyc(1500);
    host_req = 1'b1;
    wait_cyc(1502);
    host_req = 1'b0;
    wait_cyc(1530);
    host_req = 1'b1;
    wait_cyc(1532);
    host_req = 1'b0;
    wait_cyc(1560);
    host_req = 1'b1;
    wait_cyc(1562);
    host_req = 1'b0;
    samp(1800);
    check("t6_frames", fs_cyc.size() - s_fs, 2);
    check("t6_f2_start", at(fs_cyc, s_fs + 1), 1621);
    check("t6_clears", or_cyc.size() - s_or, 2);
    check("t6_f2_clear", at(or_cyc, s_or + 1), 1738);

    check("done_tracks_out_rst", bad_done, 0);
    check("sel_in_range", bad_sel, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/readout_sequencer.md
# readout_sequencer

Frame-level controller for the counter readout datapath. It arbitrates between three readout causes (RTC overflow, any channel overflow, host request), then walks the 9-input word mux (channels 1–8, then RTC). For each word it drives one PISO load cycle and 12 shift cycles, and finishes with a one-cycle clear of all counters. It sits between the channel/RTC counters and the PISO register and replaces hard-wired select sequencing with a request-driven, back-pressure-free frame schedule.

## Interface
Parameters:
- N_WORDS, 9, number of mux inputs read per frame (select values 0..N_WORDS-1; 8 = RTC word)
- WORD_W, 12, bits per word shifted out of the PISO

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous reset, active-high
- ovf_rtc  in  1  RTC overflow level from time counter
- ovf_ch  in  1  OR of channel overflows
- host_req  in  1  host readout request level
- sel  out  4  mux select {a3,a2,a1,a0}
- sl  out  1  PISO control: 1 = parallel load, 0 = shift
- frame_valid  out  1  high on cycles where serial_out carries a payload bit
- frame_start  out  1  one-cycle pulse on the first LOAD of a frame
- out_rst  out  1  one-cycle counter clear at frame end
- done  out  1  one-cycle pulse coincident with out_rst
- busy  out  1  high from first LOAD through CLEAR
- cause  out  2  latched frame cause: 0 none, 1 host, 2 ch ovf, 3 RTC ovf

## Operation
- Each request input is rising-edge detected (registered previous value) and sets a per-source pending bit. Pending is cleared when that source is granted.
- Grant priority: RTC > ch > host. Lower-priority pending bits persist to the next frame.
- States: IDLE, LOAD, SHIFT, CLEAR.
  - IDLE: if any pending, latch cause, sel=0, go to LOAD.
  - LOAD: sl=1 for 1 cycle, bit_cnt=0, go to SHIFT.
  - SHIFT: sl=0, frame_valid=1, bit_cnt increments. At bit_cnt=WORD_W-1:
    - if sel<N_WORDS-1, increment sel and go to LOAD;
    - else go to CLEAR.
  - CLEAR: out_rst=1, done=1, go to IDLE.
- Edges arriving while busy set pending and are serviced after CLEAR. A second edge from an already-pending source is absorbed; there is no counting.
- A request edge in the same cycle as CLEAR is kept pending.
- sel never exceeds N_WORDS-1. bit_cnt is 4 bits and wraps only via reload in LOAD.

## Timing
- Reset values: sel=0, sl=0, frame_valid=0, frame_start=0, out_rst=0, done=0, busy=0, cause=0; state=IDLE; pending and edge registers cleared.
- reset mid-frame: next cycle all outputs are at reset values. There is no out_rst pulse, and the aborted frame is not resumed.
- Request edge at cycle t, with the input high at t and low at t-1, in IDLE:
  - pending at t+1;
  - LOAD at t+2, frame_start=1, sel=0.
- Per word: 1 LOAD + WORD_W SHIFT = 13 cycles.
- Frame: 9×13 + 1 CLEAR = 118 cycles from first LOAD to IDLE.
- Back-to-back: if pending is set at CLEAR, the next LOAD follows 2 cycles after CLEAR (IDLE, then LOAD).
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Package readout_pkg holds:
  - state enum {IDLE, LOAD, SHIFT, CLEAR};
  - cause codes CAUSE_NONE/HOST/CH/RTC;
  - N_WORDS and WORD_W defaults;
  - RTC_SEL=8.
- One sub-module, req_arbiter: edge detect, pending bits, fixed-priority grant. Its outputs are grant_valid and grant_cause, and it takes a grant_ack input from the FSM.
- The sequencer FSM, sel counter and bit counter live in readout_sequencer.

## Test plan
- Reset, then host_req rises at cycle 10:
  - frame_start at 12 with cause=1;
  - 108 frame_valid cycles in total;
  - sel steps 0..8;
  - out_rst and done at cycle 129.
- ovf_ch and host_req rise in the same cycle:
  - first frame has cause=2;
  - second frame has cause=1, starting 2 cycles after the first CLEAR.
- ovf_rtc rises during a ch-ovf frame, at word 4:
  - the current frame completes unchanged;
  - the next frame has cause=3.
- host_req held high for 300 cycles: exactly one frame.
- reset asserted during SHIFT of word 5:
  - next cycle all outputs are 0;
  - no out_rst;
  - a later host_req edge starts a fresh frame at sel=0.
- Two host_req edges during one frame: exactly one follow-up frame.
